// File: rtl/display_sr_pkg.sv
// Shared constants for the display shift-register link: frame geometry,
// 7-segment patterns (bit0=a .. bit6=g) and BCD codes for blank/illegal digits.
package display_sr_pkg;

  localparam int FRAME_BITS = 48;
  localparam int DIGIT_BITS = 8;
  localparam int NUM_DIGITS = FRAME_BITS / DIGIT_BITS;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

endpackage

// File: rtl/display_sr_seg7_decode.sv
// Combinational 7-segment byte to BCD decoder; dp passes through, any pattern
// other than 0-9 or blank reports an error.
module seg7_decode
  import display_sr_pkg::*;
(
  input  logic [7:0] seg_byte,
  output logic [3:0] bcd,
  output logic       dp,
  output logic       err
);

  // Pattern lookup; the default arm covers every illegal segment combination
  always_comb begin
    bcd = BCD_ERR;
    err = 1'b1;
    dp  = seg_byte[7];
    case (seg_byte[6:0])
      SEG_0:     begin bcd = 4'h0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'h1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'h2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'h3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'h4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'h5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'h6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'h7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'h8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'h9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   begin bcd = BCD_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/display_sr_receiver.sv
// Deserialises 48-bit display frames from the clock's shift-register pins and
// presents a registered, decoded time snapshot with valid/error pulses.
module display_sr_receiver
  import display_sr_pkg::*;
#(
  parameter int FRAME_BITS  = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sr_clk_in,
  input  logic       sr_data_in,
  input  logic       sr_latch_in,
  output logic [3:0] hours_msd,
  output logic [3:0] hours_lsd,
  output logic [3:0] minutes_msd,
  output logic [3:0] minutes_lsd,
  output logic [3:0] seconds_msd,
  output logic [3:0] seconds_lsd,
  output logic [5:0] dp,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [5:0] digit_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] latch_sync_r;
  logic                   clk_prev_r;
  logic                   latch_prev_r;
  logic                   clk_rise_s;
  logic                   latch_rise_s;

  logic [FRAME_BITS-1:0]  shift_r;
  logic [FRAME_BITS-1:0]  shift_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   frame_ok_s;

  logic [5:0][3:0]        bcd_s;
  logic [5:0]             dp_s;
  logic [5:0]             derr_s;

  logic [5:0][3:0]        digits_r;
  logic [5:0]             dp_r;
  logic [5:0]             derr_r;
  logic                   valid_r;
  logic                   ferr_r;

  // Synchronise the three asynchronous pins and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r   <= '0;
      data_sync_r  <= '0;
      latch_sync_r <= '0;
      clk_prev_r   <= 1'b0;
      latch_prev_r <= 1'b0;
    end else begin
      clk_sync_r   <= {clk_sync_r[SYNC_STAGES-2:0], sr_clk_in};
      data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], sr_data_in};
      latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], sr_latch_in};
      clk_prev_r   <= clk_sync_r[SYNC_STAGES-1];
      latch_prev_r <= latch_sync_r[SYNC_STAGES-1];
    end
  end

  assign clk_rise_s   = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign latch_rise_s = latch_sync_r[SYNC_STAGES-1] & ~latch_prev_r;

  // Post-shift view so a latch coinciding with the last shift edge sees the full frame
  always_comb begin
    shift_next_s = shift_r;
    cnt_next_s   = cnt_r;
    if (clk_rise_s) begin
      shift_next_s = {shift_r[FRAME_BITS-2:0], data_sync_r[SYNC_STAGES-1]};
      if (cnt_r < CNT_OVER) begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
    end else begin
      shift_next_s = shift_r;
      cnt_next_s   = cnt_r;
    end
    frame_ok_s = latch_rise_s && (cnt_next_s == CNT_FULL);
  end

  // Byte 5 (first on the wire) is hours_msd, byte 0 (last) is seconds_lsd
  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_decode u_dec (
      .seg_byte (shift_next_s[g*DIGIT_BITS +: DIGIT_BITS]),
      .bcd      (bcd_s[g]),
      .dp       (dp_s[g]),
      .err      (derr_s[g])
    );
  end

  // Shift register, bit counter and registered snapshot outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r  <= '0;
      cnt_r    <= '0;
      digits_r <= {6{BCD_BLANK}};
      dp_r     <= 6'b000000;
      derr_r   <= 6'b000000;
      valid_r  <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      shift_r <= shift_next_s;
      valid_r <= frame_ok_s;
      ferr_r  <= latch_rise_s && !frame_ok_s;
      if (latch_rise_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_next_s;
      end
      if (frame_ok_s) begin
        digits_r <= bcd_s;
        dp_r     <= dp_s;
        derr_r   <= derr_s;
      end
    end
  end

  assign hours_msd   = digits_r[5];
  assign hours_lsd   = digits_r[4];
  assign minutes_msd = digits_r[3];
  assign minutes_lsd = digits_r[2];
  assign seconds_msd = digits_r[1];
  assign seconds_lsd = digits_r[0];
  assign dp          = dp_r;
  assign digit_err   = derr_r;
  assign frame_valid = valid_r;
  assign frame_err   = ferr_r;

endmodule
